// File: rtl/kws_linear_pkg.sv
// Shared constants and types for the KWS linear layer: sequencer, MAC and buffers.
package kws_linear_pkg;

    localparam int unsigned IN_MAX    = 32;
    localparam int unsigned OUT_MAX   = 32;
    localparam int unsigned CW        = $clog2(IN_MAX);
    localparam int unsigned RW        = $clog2(OUT_MAX);
    localparam int unsigned FRAC_BITS = 24;  // Q1.7.24 neuron results

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StDrain,
        StWrite,
        StDone
    } seq_state_e;

    function automatic logic len_ok(input logic [5:0] len, input int unsigned max_len);
        return (len != 6'd0) && ({26'd0, len} <= max_len);
    endfunction

endpackage

// File: rtl/linear_seq_delay.sv
// Fixed-depth shift register that aligns MAC control {en, first, last} with read data.
module linear_seq_delay #(
    parameter int unsigned Depth = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic en_i,
    input  logic first_i,
    input  logic last_i,
    output logic en_o,
    output logic first_o,
    output logic last_o
);

    logic [Depth-1:0][2:0] pipe_q;
    logic [Depth-1:0][2:0] pipe_d;

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = {en_i, first_i, last_i};
        for (int i = 1; i < int'(Depth); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_q <= '0;
        end else if (flush_i) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign en_o    = pipe_q[Depth-1][2];
    assign first_o = pipe_q[Depth-1][1];
    assign last_o  = pipe_q[Depth-1][0];

endmodule

// File: rtl/linear_seq_ctrl.sv
// Linear-layer sequencer: walks neurons x features, drives reads, MAC strobes and result writes.
module linear_seq_ctrl
    import kws_linear_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [5:0]       cfg_in_len_i,
    input  logic [5:0]       cfg_out_len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             cfg_err_o,
    output logic             feat_rd_en_o,
    output logic [CW-1:0]    feat_rd_addr_o,
    output logic             wgt_rd_en_o,
    output logic [RW+CW-1:0] wgt_rd_addr_o,
    output logic             mac_en_o,
    output logic             mac_clr_o,
    output logic             mac_last_o,
    output logic             out_wr_en_o,
    output logic [RW-1:0]    out_wr_addr_o,
    input  logic             out_wr_ready_i
);

    localparam int unsigned DW = $clog2(MEM_LAT + 2);

    seq_state_e    state_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] n_m1_q;
    logic [RW-1:0] m_m1_q;
    logic [DW-1:0] drain_q;
    logic          cfg_err_q;

    logic issue;
    logic abort_act;

    assign issue     = (state_q == StIssue);
    assign abort_act = abort_i && (state_q != StIdle);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            col_q     <= '0;
            row_q     <= '0;
            n_m1_q    <= '0;
            m_m1_q    <= '0;
            drain_q   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            if (abort_act) begin
                state_q <= StIdle;
                col_q   <= '0;
                row_q   <= '0;
                drain_q <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start_i) begin
                            if (len_ok(cfg_in_len_i, IN_MAX) && len_ok(cfg_out_len_i, OUT_MAX)) begin
                                n_m1_q  <= CW'(cfg_in_len_i - 6'd1);
                                m_m1_q  <= RW'(cfg_out_len_i - 6'd1);
                                col_q   <= '0;
                                row_q   <= '0;
                                state_q <= StIssue;
                            end else begin
                                cfg_err_q <= 1'b1;
                            end
                        end
                    end
                    StIssue: begin
                        if (col_q == n_m1_q) begin
                            col_q   <= '0;
                            drain_q <= '0;
                            state_q <= StDrain;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                    // Wait for the last product to land and the MAC result to settle.
                    StDrain: begin
                        if (drain_q == DW'(MEM_LAT)) begin
                            state_q <= StWrite;
                        end else begin
                            drain_q <= drain_q + 1'b1;
                        end
                    end
                    StWrite: begin
                        if (out_wr_ready_i) begin
                            if (row_q == m_m1_q) begin
                                state_q <= StDone;
                            end else begin
                                row_q   <= row_q + 1'b1;
                                state_q <= StIssue;
                            end
                        end
                    end
                    StDone:  state_q <= StIdle;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    linear_seq_delay #(
        .Depth (MEM_LAT)
    ) u_delay (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (abort_act),
        .en_i    (issue),
        .first_i (issue && (col_q == '0)),
        .last_i  (issue && (col_q == n_m1_q)),
        .en_o    (mac_en_o),
        .first_o (mac_clr_o),
        .last_o  (mac_last_o)
    );

    assign busy_o         = (state_q == StIssue) || (state_q == StDrain) || (state_q == StWrite);
    assign done_o         = (state_q == StDone);
    assign cfg_err_o      = cfg_err_q;
    assign feat_rd_en_o   = issue;
    assign feat_rd_addr_o = issue ? col_q : '0;
    assign wgt_rd_en_o    = issue;
    assign wgt_rd_addr_o  = issue ? {row_q, col_q} : '0;
    assign out_wr_en_o    = (state_q == StWrite);
    assign out_wr_addr_o  = (state_q == StWrite) ? row_q : '0;

endmodule
